// File: rtl/fila_cmd.sv
// rtl/fila_cmd.sv - button-driven command front-end for the 8-entry queue
// Synchronises and debounces two buttons, then issues one guarded enqueue/dequeue strobe per press.
module fila_cmd #(
  parameter int DEBOUNCE_CYC = 100,
  parameter int DEPTH        = 8
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       btn_enq,
  input  logic       btn_deq,
  input  logic [7:0] sw_data,
  input  logic [7:0] len_in,
  output logic [7:0] data_out,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic       err_out,
  output logic       full_out,
  output logic       empty_out,
  output logic [7:0] op_count
);

  localparam logic [7:0] LP_CNT_MAX = 8'(DEBOUNCE_CYC - 1);
  localparam logic [7:0] LP_DEPTH   = 8'(DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT_REL} state_t;

  // bit 0 = enqueue button, bit 1 = dequeue button
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_deb;
  logic [1:0] r_deb_q;
  logic [7:0] r_cnt [2];

  state_t     r_state;
  logic [7:0] r_data;
  logic       r_enq;
  logic       r_deq;
  logic       r_err;
  logic [7:0] r_op_count;

  state_t     w_state_nxt;
  logic [7:0] w_data_nxt;
  logic       w_enq_nxt;
  logic       w_deq_nxt;
  logic       w_err_nxt;
  logic [7:0] w_op_count_nxt;
  logic [1:0] w_req;
  logic       w_full;
  logic       w_empty;

  assign w_full  = (len_in >= LP_DEPTH);
  assign w_empty = (len_in == 8'd0);
  assign w_req   = r_deb & ~r_deb_q;

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int b = 0; b < 2; b++) r_cnt[b] <= '0;
    end else begin
      r_s1    <= {btn_deq, btn_enq};
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      // deb only follows s2 after DEBOUNCE_CYC consecutive differing samples
      for (int b = 0; b < 2; b++) begin
        if (r_s2[b] != r_deb[b]) begin
          if (r_cnt[b] == LP_CNT_MAX) begin
            r_deb[b] <= r_s2[b];
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + 8'd1;
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_enq_nxt      = 1'b0;
    w_deq_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_op_count_nxt = r_op_count;
    case (r_state)
      ST_IDLE: begin
        // enqueue wins a simultaneous press, matching the queue's own priority
        if (w_req[0]) begin
          w_state_nxt = ST_WAIT_REL;
          if (!w_full) begin
            w_enq_nxt      = 1'b1;
            w_data_nxt     = sw_data;
            w_op_count_nxt = r_op_count + 8'd1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_req[1]) begin
          w_state_nxt = ST_WAIT_REL;
          if (!w_empty) begin
            w_deq_nxt      = 1'b1;
            w_op_count_nxt = r_op_count + 8'd1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_REL: begin
        if (r_deb == 2'b00) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_enq      <= 1'b0;
      r_deq      <= 1'b0;
      r_err      <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_enq      <= w_enq_nxt;
      r_deq      <= w_deq_nxt;
      r_err      <= w_err_nxt;
      r_op_count <= w_op_count_nxt;
    end
  end

  assign data_out    = r_data;
  assign enqueue_out = r_enq;
  assign dequeue_out = r_deq;
  assign err_out     = r_err;
  assign op_count    = r_op_count;
  assign full_out    = w_full;
  assign empty_out   = w_empty;

endmodule

// File: tb/tb_fila_cmd.sv
// tb/tb_fila_cmd.sv - self-checking bench for fila_cmd
// Expected behaviour comes from press-level rules: latency, guard on len, one op per press, mod-256 count.
`timescale 1us/1ns
module tb_fila_cmd;
  localparam int D     = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_enq;
  logic       btn_deq;
  logic [7:0] sw_data;
  logic [7:0] len_in;
  logic [7:0] data_out;
  logic       enqueue_out;
  logic       dequeue_out;
  logic       err_out;
  logic       full_out;
  logic       empty_out;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;
  int n_enq, n_deq, n_err, n_overlap, n_data_chg;
  int first_enq, first_deq, first_err;

  always #50 clk = ~clk;

  fila_cmd #(.DEBOUNCE_CYC(D), .DEPTH(DEPTH)) dut (
    .clk_10KHz  (clk),
    .reset      (reset),
    .btn_enq    (btn_enq),
    .btn_deq    (btn_deq),
    .sw_data    (sw_data),
    .len_in     (len_in),
    .data_out   (data_out),
    .enqueue_out(enqueue_out),
    .dequeue_out(dequeue_out),
    .err_out    (err_out),
    .full_out   (full_out),
    .empty_out  (empty_out),
    .op_count   (op_count)
  );

  task automatic clr_counts();
    n_enq = 0; n_deq = 0; n_err = 0; n_overlap = 0; n_data_chg = 0;
    first_enq = -1; first_deq = -1; first_err = -1;
  endtask

  // index i = observation just after the i-th rising edge since the call
  task automatic run(input int n);
    logic [7:0] prev;
    for (int i = 0; i < n; i++) begin
      prev = data_out;
      @(posedge clk); #1;
      if (enqueue_out) begin n_enq++; if (first_enq < 0) first_enq = i; end
      if (dequeue_out) begin n_deq++; if (first_deq < 0) first_deq = i; end
      if (err_out)     begin n_err++; if (first_err < 0) first_err = i; end
      if (int'(enqueue_out) + int'(dequeue_out) + int'(err_out) > 1) n_overlap++;
      if (!enqueue_out && data_out !== prev) n_data_chg++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; btn_enq = 1'b0; btn_deq = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic press(input logic e, input logic q);
    clr_counts();
    btn_enq = e; btn_deq = q;
    run(D + 8);
    btn_enq = 1'b0; btn_deq = 1'b0;
    run(D + 6);
  endtask

  task automatic test_reset();
    len_in = 8'd0; sw_data = 8'h00;
    reset = 1'b0; btn_enq = 1'b0; btn_deq = 1'b0;
    #3;
    checks++;
    if ({data_out, enqueue_out, dequeue_out, err_out, op_count} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs got %0h want 0", {data_out, enqueue_out, dequeue_out, err_out, op_count});
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_flags();
    logic [7:0] lens [10];
    lens = '{8'd0, 8'd7, 8'd8, 8'd9, 8'd255, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int k = 6; k < 10; k++) lens[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 10; k++) begin
      len_in = lens[k]; #1;
      checks++;
      if ({full_out, empty_out} !== {(int'(lens[k]) >= DEPTH), (lens[k] == 8'd0)}) begin
        errors++; $display("FAIL flags len=%0d got full=%b empty=%b", lens[k], full_out, empty_out);
      end
    end
    len_in = 8'd0;
  endtask

  task automatic test_latency();
    do_reset();
    sw_data = 8'hA5; len_in = 8'd0;
    clr_counts();
    btn_enq = 1'b1;
    run(20);
    checks++;
    if (first_enq !== D + 2 || n_enq !== 1) begin
      errors++; $display("FAIL latency got first=%0d count=%0d want first=%0d count=1", first_enq, n_enq, D + 2);
    end
    checks++;
    if (n_deq + n_err + n_overlap !== 0) begin
      errors++; $display("FAIL latency_other got %0d want 0", n_deq + n_err + n_overlap);
    end
    checks++;
    if (data_out !== 8'hA5 || op_count !== 8'd1) begin
      errors++; $display("FAIL latency_data got data=%0h cnt=%0d want a5 1", data_out, op_count);
    end
    btn_enq = 1'b0;
    clr_counts();
    run(D + 6);
    checks++;
    if (n_enq + n_deq + n_err !== 0) begin
      errors++; $display("FAIL release_strobe got %0d want 0", n_enq + n_deq + n_err);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    len_in = 8'd3;
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      btn_enq = (i % 2 == 0);
      run(1);
    end
    btn_enq = 1'b0;
    run(D + 6);
    checks++;
    if (n_enq + n_deq + n_err !== 0) begin
      errors++; $display("FAIL bounce got %0d strobes want 0", n_enq + n_deq + n_err);
    end
    clr_counts();
    for (int k = 0; k < 8; k++) begin
      len_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) btn_enq = 1'b1; else btn_deq = 1'b1;
      run($urandom_range(1, D - 1));
      btn_enq = 1'b0; btn_deq = 1'b0;
      run($urandom_range(1, 3));
    end
    run(D + 6);
    checks++;
    if (n_enq + n_deq + n_err !== 0) begin
      errors++; $display("FAIL glitch got %0d strobes want 0", n_enq + n_deq + n_err);
    end
  endtask

  task automatic test_reject();
    logic [7:0] v;
    do_reset();
    v = 8'($urandom_range(1, 255));
    sw_data = v; len_in = 8'd0;
    press(1'b1, 1'b0);
    len_in = 8'($urandom_range(DEPTH, 255));
    sw_data = ~v;
    press(1'b1, 1'b0);
    checks++;
    if (n_err !== 1 || first_err !== D + 2 || n_enq !== 0) begin
      errors++; $display("FAIL reject_full got err=%0d at %0d enq=%0d want 1 at %0d 0", n_err, first_err, n_enq, D + 2);
    end
    checks++;
    if (data_out !== v || op_count !== 8'd1) begin
      errors++; $display("FAIL reject_full_data got data=%0h cnt=%0d want %0h 1", data_out, op_count, v);
    end
    len_in = 8'd0;
    press(1'b0, 1'b1);
    checks++;
    if (n_err !== 1 || n_deq !== 0 || op_count !== 8'd1) begin
      errors++; $display("FAIL reject_empty got err=%0d deq=%0d cnt=%0d want 1 0 1", n_err, n_deq, op_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    do_reset();
    v = 8'($urandom_range(0, 255));
    sw_data = v;
    len_in = 8'($urandom_range(1, DEPTH - 1));
    press(1'b1, 1'b1);
    checks++;
    if (n_enq !== 1 || n_deq !== 0 || n_err !== 0 || data_out !== v) begin
      errors++; $display("FAIL simul got enq=%0d deq=%0d err=%0d data=%0h want 1 0 0 %0h", n_enq, n_deq, n_err, data_out, v);
    end
    press(1'b0, 1'b1);
    checks++;
    if (n_deq !== 1 || first_deq !== D + 2 || op_count !== 8'd2) begin
      errors++; $display("FAIL simul_deq got deq=%0d at %0d cnt=%0d want 1 at %0d 2", n_deq, first_deq, op_count, D + 2);
    end
  endtask

  task automatic test_wrap();
    int exp_count, tot_enq, tot_deq, tot_err, bad_data, bad_ovl;
    logic [7:0] v;
    do_reset();
    exp_count = 0; tot_enq = 0; tot_deq = 0; tot_err = 0; bad_data = 0; bad_ovl = 0;
    for (int k = 0; k < 256; k++) begin
      if (k % 2 == 0) begin
        v = 8'($urandom_range(0, 255));
        sw_data = v; len_in = 8'd0;
        press(1'b1, 1'b0);
        if (data_out !== v) bad_data++;
      end else begin
        len_in = 8'd1;
        press(1'b0, 1'b1);
      end
      tot_enq += n_enq; tot_deq += n_deq; tot_err += n_err;
      bad_ovl += n_overlap + n_data_chg;
      exp_count = (exp_count + 1) % 256;
      if (k == 254) begin
        checks++;
        if (op_count !== 8'(exp_count)) begin
          errors++; $display("FAIL wrap_255 got %0d want %0d", op_count, exp_count);
        end
      end
    end
    checks++;
    if (tot_enq !== 128 || tot_deq !== 128 || tot_err !== 0) begin
      errors++; $display("FAIL wrap_ops got enq=%0d deq=%0d err=%0d want 128 128 0", tot_enq, tot_deq, tot_err);
    end
    checks++;
    if (bad_data !== 0 || bad_ovl !== 0) begin
      errors++; $display("FAIL wrap_data got bad=%0d ovl=%0d want 0 0", bad_data, bad_ovl);
    end
    checks++;
    if (op_count !== 8'(exp_count)) begin
      errors++; $display("FAIL wrap_zero got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    v = 8'($urandom_range(1, 255));
    sw_data = v; len_in = 8'd0;
    press(1'b1, 1'b0);
    clr_counts();
    btn_enq = 1'b1;
    run(4);
    #10 reset = 1'b0;
    #1;
    checks++;
    if ({data_out, enqueue_out, dequeue_out, err_out, op_count} !== 19'd0 || n_enq !== 0) begin
      errors++; $display("FAIL reset_mid got %0h enq=%0d want 0 0", {data_out, enqueue_out, dequeue_out, err_out, op_count}, n_enq);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    clr_counts();
    run(20);
    checks++;
    if (n_enq !== 1 || first_enq !== D + 2) begin
      errors++; $display("FAIL reset_mid_press got count=%0d at %0d want 1 at %0d", n_enq, first_enq, D + 2);
    end
    checks++;
    if (data_out !== v || op_count !== 8'd1) begin
      errors++; $display("FAIL reset_mid_data got data=%0h cnt=%0d want %0h 1", data_out, op_count, v);
    end
    btn_enq = 1'b0;
    run(D + 6);
  endtask

  initial begin
    reset = 1'b0; btn_enq = 1'b0; btn_deq = 1'b0; sw_data = 8'h00; len_in = 8'h00;
    test_reset();
    test_flags();
    test_latency();
    test_bounce();
    test_reject();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
